mem_write_arbiter: RTL and testbench

//   Round-robin arbiter for the single write port of the accelerator scratchpad memory.

---
 rtl/accel_pkg.sv | 22 ++
 rtl/mem_write_arbiter_rr_pick.sv | 38 +++
 rtl/mem_write_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_write_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared constants and types for the scratchpad write path
//
// Purpose: memory geometry, requester IDs and the write-arbiter state type
// shared by the accelerator datapath blocks.
package accel_pkg;

  localparam int NUM_SIZE        = 16;  // scratchpad data word width
  localparam int WORDS_IN_MEMORY = 32;  // scratchpad depth
  localparam int ADDR_W          = 5;   // scratchpad address width
  localparam int NUM_REQ         = 3;   // write-port requesters
  localparam int MAX_BURST       = 8;   // beats before a burst is forcibly released

  localparam int REQ_MXU  = 0;
  localparam int REQ_VPU  = 1;
  localparam int REQ_HOST = 2;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/mem_write_arbiter_rr_pick.sv
// rtl/mem_write_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: pick the first asserted request at or after ptr, wrapping to 0.
// Ports:
//   req    in   N      request vector
//   ptr    in   PTR_W  highest-priority index this cycle (0..N-1)
//   grant  out  N      one-hot winner, zero when no request
//   any    out  1      at least one request asserted
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);

  // Two passes: first look at indices >= ptr, then fall back to the lowest
  // asserted index overall, which can only be below ptr at that point.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        any      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - round-robin burst arbiter for the scratchpad write port
//
// Purpose: grants whole valid/ready bursts from MXU (0), VPU (1) and host (2)
// and registers the accepted beat onto the memory write port one cycle later.
// Bursts longer than MAX_BURST beats are cut and the requester re-arbitrates.
// Optional feature macro: MEM_ARB_STATS_EN adds per-requester saturating
// beat and stall counters on stat_beats / stat_stalls.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   req_valid    in   NUM_REQ            per-requester beat valid
//   req_last     in   NUM_REQ            beat is final of its burst
//   req_addr     in   NUM_REQ*ADDR_W     flat, requester i at [i*ADDR_W +: ADDR_W]
//   req_data     in   NUM_REQ*NUM_SIZE   flat, requester i at [i*NUM_SIZE +: NUM_SIZE]
//   req_ready    out  NUM_REQ            beat accepted this cycle (one-hot or zero)
//   mem_we       out  1                  registered write enable
//   mem_addr     out  ADDR_W             registered write address
//   mem_wdata    out  NUM_SIZE           registered write data
//   busy         out  1                  a burst is currently granted
//   err_oob      out  1                  pulse: accepted beat had addr >= WORDS
//   err_burst    out  1                  pulse: burst force-released at MAX_BURST
//   stat_beats   out  NUM_REQ*16         (MEM_ARB_STATS_EN) accepted beats per requester
//   stat_stalls  out  NUM_REQ*16         (MEM_ARB_STATS_EN) valid && !ready cycles
module mem_write_arbiter #(
  parameter int NUM_REQ   = accel_pkg::NUM_REQ,
  parameter int NUM_SIZE  = accel_pkg::NUM_SIZE,
  parameter int ADDR_W    = accel_pkg::ADDR_W,
  parameter int WORDS     = accel_pkg::WORDS_IN_MEMORY,
  parameter int MAX_BURST = accel_pkg::MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [NUM_SIZE-1:0]          mem_wdata,
  output logic                         busy,
  output logic                         err_oob,
  output logic                         err_burst
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        stat_beats,
  output logic [NUM_REQ*16-1:0]        stat_stalls
`endif
);

  import accel_pkg::*;

  localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [31:0] WORDS_L = 32'(WORDS);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [NUM_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  err_oob_q, err_oob_d;
  logic                  err_burst_q, err_burst_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic                  pick_any;
  logic [PTR_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [NUM_REQ-1:0]    ready;
  logic [PTR_W-1:0]      acc_idx;
  logic                  acc;
  logic [ADDR_W-1:0]     beat_addr;
  logic [NUM_SIZE-1:0]   beat_data;
  logic                  beat_last;
  logic                  beat_oob;
  logic                  cap_hit;
  logic                  rel;
  logic [PTR_W-1:0]      next_ptr;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) win_idx = PTR_W'(i);
    end
  end

  // In IDLE the picker's winner is accepted in the same cycle so a burst's
  // first beat costs no bubble. Ready is held low while rst is asserted so
  // nothing is consumed that the reset would then discard.
  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    ready = '0;
    if (!rst) begin
      if (state_q == ARB_IDLE) ready = pick_grant;
      else                     ready = owner_oh & req_valid;
    end
  end

  always_comb begin
    acc_idx   = (state_q == ARB_IDLE) ? win_idx : owner_q;
    acc       = (|ready) && ((state_q != ARB_IDLE) || pick_any);
    beat_addr = req_addr[int'(acc_idx)*ADDR_W +: ADDR_W];
    beat_data = req_data[int'(acc_idx)*NUM_SIZE +: NUM_SIZE];
    beat_last = req_last[acc_idx];
    beat_oob  = 32'(beat_addr) >= WORDS_L;
    cap_hit   = beat_cnt_q == CNT_W'(MAX_BURST - 1);
    rel       = acc && (beat_last || cap_hit);
    next_ptr  = (acc_idx == PTR_W'(NUM_REQ - 1)) ? '0 : acc_idx + PTR_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    mem_we_d    = acc && !beat_oob;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_oob_d   = acc && beat_oob;
    err_burst_d = rel && !beat_last;

    if (mem_we_d) begin
      mem_addr_d  = beat_addr;
      mem_wdata_d = beat_data;
    end

    if (acc) begin
      if (rel) begin
        state_d    = ARB_IDLE;
        rr_ptr_d   = next_ptr;
        beat_cnt_d = '0;
      end else begin
        state_d    = ARB_BURST;
        owner_d    = acc_idx;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == ARB_BURST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_oob_q   <= 1'b0;
      err_burst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      err_oob_q   <= err_oob_d;
      err_burst_q <= err_burst_d;
    end
  end

  assign req_ready = ready;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err_oob   = err_oob_q;
  assign err_burst = err_burst_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] beats_q  [NUM_REQ];
  logic [15:0] beats_d  [NUM_REQ];
  logic [15:0] stalls_q [NUM_REQ];
  logic [15:0] stalls_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beats_d[i]  = beats_q[i];
      stalls_d[i] = stalls_q[i];
      if (ready[i] && (beats_q[i] != 16'hFFFF))
        beats_d[i] = beats_q[i] + 16'd1;
      if (req_valid[i] && !ready[i] && (stalls_q[i] != 16'hFFFF))
        stalls_d[i] = stalls_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beats_q[i]  <= '0;
        stalls_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beats_q[i]  <= beats_d[i];
        stalls_q[i] <= stalls_d[i];
      end
    end
  end

  always_comb begin
    stat_beats  = '0;
    stat_stalls = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_beats[i*16 +: 16]  = beats_q[i];
      stat_stalls[i*16 +: 16] = stalls_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - scoreboard bench for mem_write_arbiter
module tb_mem_write_arbiter;
  import accel_pkg::*;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int WD = 32;
  localparam int MB = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              busy;
  logic              err_oob;
  logic              err_burst;
`ifdef MEM_ARB_STATS_EN
  logic [NR*16-1:0]  stat_beats;
  logic [NR*16-1:0]  stat_stalls;
`endif

  beat_t src_q [NR][$];
  wr_t   exp_q [$];
  int    acc_q [$];
  int    oob_q [$];
  int    wr_cyc_q [$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int burst_pulses = 0;
  int oob_pulses = 0;
  int burst_at_wr = -1;

  mem_write_arbiter #(
    .NUM_REQ   (NR),
    .NUM_SIZE  (DW),
    .ADDR_W    (AW),
    .WORDS     (WD),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .err_oob   (err_oob),
    .err_burst (err_burst)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_beat(input int r, input int addr, input int data, input bit last, input int gap);
    beat_t b;
    b.addr = AW'(addr);
    b.data = DW'(data);
    b.last = last;
    b.gap  = gap;
    src_q[r].push_back(b);
  endtask

  task automatic expect_wr(input int addr, input int data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = DW'(data);
    exp_q.push_back(w);
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0) && (acc_q.size() == 0) && (oob_q.size() == 0);
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      #3;
      n++;
      done = all_empty();
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  // Requester models: present the queue head, honour per-beat gaps, pop on
  // acceptance and stamp the cycle the DUT should show the result.
  initial begin
    bit    took [NR];
    bit    fresh [NR];
    int    gap_left [NR];
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      fresh[i] = 1'b1;
      gap_left[i] = 0;
      took[i] = 1'b0;
    end
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NR; i++) took[i] = req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (took[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          if (32'(b.addr) >= WD) oob_q.push_back(cyc);
          else                   acc_q.push_back(cyc);
          fresh[i] = 1'b1;
        end
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          if (fresh[i]) begin
            gap_left[i] = b.gap;
            fresh[i] = 1'b0;
          end
          if (gap_left[i] > 0) begin
            req_valid[i] = 1'b0;
            gap_left[i]--;
          end else begin
            req_valid[i] = 1'b1;
            req_last[i]  = b.last;
            req_addr[i*AW +: AW] = b.addr;
            req_data[i*DW +: DW] = b.data;
          end
        end else begin
          req_valid[i] = 1'b0;
          fresh[i] = 1'b1;
        end
      end
    end
  end

  // Output monitor / scoreboard.
  initial forever begin
    wr_t w;
    @(negedge clk);
    if (!rst) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w.addr));
          check("wr_data", 32'(mem_wdata), 32'(w.data));
        end
        if (acc_q.size() == 0) check("wr_no_accept", 32'(mem_we), 32'd0);
        else                   check("wr_latency", 32'(cyc), 32'(acc_q.pop_front()));
        wr_cyc_q.push_back(cyc);
      end
      if (err_oob) begin
        oob_pulses++;
        check("oob_no_we", 32'(mem_we), 32'd0);
        if (oob_q.size() == 0) check("oob_unexpected", 32'(err_oob), 32'd0);
        else                   check("oob_latency", 32'(cyc), 32'(oob_q.pop_front()));
      end
      if (err_burst) begin
        burst_pulses++;
        burst_at_wr = wr_cyc_q.size();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int o0;
    rst = 1'b1;

    // Reset state; both requesters valid during reset must see no ready.
    push_beat(REQ_MXU, 3, 'h00A0, 1'b1, 0);
    push_beat(REQ_HOST, 4, 'h00C2, 1'b1, 0);
    expect_wr(3, 'h00A0);
    expect_wr(4, 'h00C2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_oob", 32'(err_oob), 32'd0);
    check("rst_err_burst", 32'(err_burst), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid_seen", 32'(req_valid), 32'b101);
    rst = 1'b0;

    // req0 and req2 single beats from reset: req0 first, req2 next cycle.
    wr_cyc_q.delete();
    drain("s2", 50);
    check("s2_nwr", 32'(wr_cyc_q.size()), 32'd2);
    if (wr_cyc_q.size() == 2) check("s2_b2b", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);

    // req0 4-beat burst with a mid-burst bubble; req1 must wait for its last.
    wr_cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      push_beat(REQ_MXU, 16 + k, 'h100 + k, k == 3, (k == 2) ? 2 : 0);
      expect_wr(16 + k, 'h100 + k);
    end
    for (int k = 0; k < 2; k++) push_beat(REQ_VPU, 20 + k, 'h200 + k, k == 1, 0);
    for (int k = 0; k < 2; k++) expect_wr(20 + k, 'h200 + k);
    drain("s3", 100);
    check("s3_nwr", 32'(wr_cyc_q.size()), 32'd6);

    // Only req1: 3 beats addr 8..10, data 1..3, written on consecutive cycles.
    wr_cyc_q.delete();
    for (int k = 0; k < 3; k++) begin
      push_beat(REQ_VPU, 8 + k, 1 + k, k == 2, 0);
      expect_wr(8 + k, 1 + k);
    end
    drain("s1", 50);
    check("s1_nwr", 32'(wr_cyc_q.size()), 32'd3);
    if (wr_cyc_q.size() == 3) check("s1_span", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);

    // req2 streams 10 beats: cut after 8 with err_burst, then re-arbitrates.
    wr_cyc_q.delete();
    b0 = burst_pulses;
    for (int k = 0; k < 10; k++) begin
      push_beat(REQ_HOST, k, 'h300 + k, k == 9, 0);
      expect_wr(k, 'h300 + k);
    end
    repeat (3) @(negedge clk);
    check("s4_busy", 32'(busy), 32'd1);
    drain("s4", 100);
    check("s4_nwr", 32'(wr_cyc_q.size()), 32'd10);
    check("s4_burst_pulses", 32'(burst_pulses - b0), 32'd1);
    check("s4_burst_at_beat", 32'(burst_at_wr), 32'd8);

    // req0 addr 31 (last word) then addr 32 (out of range).
    wr_cyc_q.delete();
    o0 = oob_pulses;
    push_beat(REQ_MXU, 31, 'hBEEF, 1'b0, 0);
    push_beat(REQ_MXU, 32, 'hDEAD, 1'b1, 0);
    expect_wr(31, 'hBEEF);
    drain("s5", 50);
    check("s5_nwr", 32'(wr_cyc_q.size()), 32'd1);
    check("s5_oob_pulses", 32'(oob_pulses - o0), 32'd1);
    check("s5_addr_hold", 32'(mem_addr), 32'd31);

    // Reset on the 2nd beat of a 4-beat req1 burst.
    wr_cyc_q.delete();
    for (int k = 0; k < 4; k++) push_beat(REQ_VPU, 12 + k, 'h400 + k, k == 3, 0);
    begin
      int n;
      n = 0;
      while (src_q[REQ_VPU].size() != 3 && n < 50) begin
        @(posedge clk);
        #3;
        n++;
      end
      check("s6_first_beat", 32'(src_q[REQ_VPU].size()), 32'd3);
    end
    rst = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    acc_q.delete();
    oob_q.delete();
    @(negedge clk);
    check("s6_rst_we", 32'(mem_we), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_ready", 32'(req_ready), 32'd0);
    check("s6_rst_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_beat(REQ_HOST, 5, 'h500, 1'b1, 0);
    push_beat(REQ_MXU, 6, 'h600, 1'b1, 0);
    expect_wr(6, 'h600);
    expect_wr(5, 'h500);
    drain("s6", 50);
    check("s6_nwr", 32'(wr_cyc_q.size()), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
